// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Package    : seq_det_pkg
// Purpose    : Shared types and constants for the serial pattern detector.
//              Holds the detector FSM state encoding and the overlap-mode
//              constants used when decoding the captured overlap flag.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  // Detector FSM: FILL while fewer than PAT_W-1 history bits are valid,
  // ARMED once a full window can be formed with the incoming bit.
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Overlap mode encoding for the captured overlap flag.
  localparam logic OVL_OFF = 1'b0;
  localparam logic OVL_ON  = 1'b1;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// ============================================================================
// Module     : sat_cnt
// Purpose    : Up-counter that sticks at its all-ones value instead of
//              wrapping. A synchronous clear takes priority over increment.
// Ports      : clk  in  1  clock, rising edge
//              rst  in  1  asynchronous active-high reset (q -> 0)
//              clr  in  1  synchronous clear
//              inc  in  1  increment request
//              q    out W  current count
// Revision   : 1.0 - initial release
// ============================================================================
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic at_max;

  assign at_max = (q == {W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + W'(1);
    end
  end

endmodule : sat_cnt
`default_nettype wire

// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
// Module     : seq_det_param
// Purpose    : Parameterised serial pattern detector with a Mealy match flag,
//              run-time loadable pattern and overlap mode, and an optional
//              saturating match counter.
// Config     : SEQ_DET_CNT_EN - when defined, the match counter is built;
//              otherwise match_cnt is tied to zero.
// Ports      : clk       in  1      clock, rising edge
//              rst       in  1      asynchronous active-high reset
//              x         in  1      serial data bit, pattern MSB first
//              en        in  1      x valid this cycle
//              load      in  1      capture pattern/overlap, restart
//              pattern   in  PAT_W  pattern to capture on load
//              overlap   in  1      overlap mode to capture on load
//              z         out 1      match flag (combinational, same cycle)
//              armed     out 1      PAT_W-1 history bits are held
//              match_cnt out CNT_W  saturating match count
// Revision   : 1.0 - initial release
// ============================================================================
module seq_det_param #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1010),
  parameter logic             RST_OVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             z,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  import seq_det_pkg::*;

  // Fill counter only has to reach PAT_W-1.
  localparam int               FILL_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   pat_q, pat_nxt;
  logic               ovl_q, ovl_nxt;
  logic [PAT_W-2:0]   hist, hist_nxt;
  logic [FILL_W-1:0]  fill_cnt, fill_nxt;
  logic [FILL_W-1:0]  fill_inc;
  logic [PAT_W-1:0]   window;
  logic               match;

  // The candidate window is the held history with the live bit appended,
  // which is what gives the zero-latency match on the last pattern bit.
  assign window   = {hist, x};
  assign match    = (window == pat_q);
  assign fill_inc = fill_cnt + FILL_W'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      pat_q    <= RST_PAT;
      ovl_q    <= RST_OVL;
      hist     <= '0;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pat_q    <= pat_nxt;
      ovl_q    <= ovl_nxt;
      hist     <= hist_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pat_nxt   = pat_q;
    ovl_nxt   = ovl_q;
    hist_nxt  = hist;
    fill_nxt  = fill_cnt;

    if (load) begin
      // Load dominates en: the current x is not consumed.
      pat_nxt   = pattern;
      ovl_nxt   = overlap;
      fill_nxt  = '0;
      state_nxt = FILL;
    end else if (en) begin
      if (z && (ovl_q == OVL_OFF)) begin
        // Non-overlap: discard the matched bits by restarting the fill.
        // History contents are irrelevant while filling, so leave them.
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        hist_nxt = window[PAT_W-2:0];
        if (state == FILL) begin
          fill_nxt = fill_inc;
          if (fill_inc == FILL_FULL) begin
            state_nxt = ARMED;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    armed = (state == ARMED);
    z     = en & ~load & armed & match;
  end

  // --------------------------------------------------------------------------
  // Match counter
  // --------------------------------------------------------------------------
`ifdef SEQ_DET_CNT_EN
  sat_cnt #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .inc (z),
    .q   (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule : seq_det_param
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// ============================================================================
// Module     : tb_seq_det_param
// Purpose    : Self-checking bench for seq_det_param. Three instances run in
//              lock-step: default (PAT_W=4, CNT_W=8), PAT_W=6, and CNT_W=2.
//              A sliding-window model of the bit stream supplies every
//              expected output.
// Ports      : none
// Revision   : 1.0 - initial release
// ============================================================================
module tb_seq_det_param;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       x, en, load, overlap;
  logic [3:0] pat4;
  logic [5:0] pat6;

  logic [2:0] zz, aa;
  logic [7:0] cnt_d4, cnt_d6;
  logic [1:0] cnt_c2;

  int n_checks = 0;
  int n_pass   = 0;
  int hits4    = 0;
  int hits6    = 0;

  // Model state, one slot per instance
  int          W    [3] = '{4, 6, 4};
  int          CMAX [3] = '{255, 255, 3};
  logic [31:0] hv   [3];
  logic [31:0] mp   [3];
  bit          mo   [3];
  int          len  [3];
  int          mc   [3];

  seq_det_param u_d4 (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern(pat4),
    .overlap(overlap), .z(zz[0]), .armed(aa[0]), .match_cnt(cnt_d4));

  seq_det_param #(.PAT_W(6)) u_d6 (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern(pat6),
    .overlap(overlap), .z(zz[1]), .armed(aa[1]), .match_cnt(cnt_d6));

  seq_det_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern(pat4),
    .overlap(overlap), .z(zz[2]), .armed(aa[2]), .match_cnt(cnt_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic void model_reset(int i);
    mp[i]  = 32'd10;
    mo[i]  = 1'b0;
    hv[i]  = '0;
    len[i] = 0;
    mc[i]  = 0;
  endfunction

  // Match when the last W-1 consumed bits plus the live bit equal the pattern
  function automatic bit model_z(int i, bit xi, bit ei, bit li);
    logic [31:0] mask;
    logic [31:0] win;
    mask = (32'd1 << W[i]) - 32'd1;
    win  = ((hv[i] << 1) | 32'(xi)) & mask;
    return ei && !li && (len[i] >= W[i] - 1) && (win == mp[i]);
  endfunction

  function automatic void model_update(int i, bit xi, bit ei, bit li, bit oi,
                                       logic [31:0] p, bit zi);
    if (li) begin
      mp[i] = p; mo[i] = oi; hv[i] = '0; len[i] = 0; mc[i] = 0;
    end else if (ei) begin
      if (zi && mc[i] < CMAX[i]) mc[i]++;
      if (zi && !mo[i]) begin
        len[i] = 0;
      end else begin
        hv[i] = (hv[i] << 1) | 32'(xi);
        if (len[i] < W[i]) len[i]++;
      end
    end
  endfunction

  function automatic logic [31:0] dut_cnt(int i);
    case (i)
      0:       return 32'(cnt_d4);
      1:       return 32'(cnt_d6);
      default: return 32'(cnt_c2);
    endcase
  endfunction

  // One cycle: drive on the falling edge, check just after, advance model on
  // the rising edge. Reset applies to the model immediately (asynchronous).
  task automatic step(input bit r, input bit xi, input bit ei, input bit li,
                      input bit oi, input logic [3:0] p4i, input logic [5:0] p6i);
    bit ez [3];
    @(negedge clk);
    rst = r; x = xi; en = ei; load = li; overlap = oi; pat4 = p4i; pat6 = p6i;
    #1;
    if (r) for (int i = 0; i < 3; i++) model_reset(i);
    for (int i = 0; i < 3; i++) begin
      ez[i] = !r && model_z(i, xi, ei, li);
      check($sformatf("z[%0d]", i), 32'(zz[i]), 32'(ez[i]));
      check($sformatf("armed[%0d]", i), 32'(aa[i]), 32'(len[i] >= W[i] - 1));
      check($sformatf("cnt[%0d]", i), dut_cnt(i), CNT_ON ? 32'(mc[i]) : 32'd0);
    end
    if (zz[0]) hits4++;
    if (zz[1]) hits6++;
    @(posedge clk);
    if (!r)
      for (int i = 0; i < 3; i++)
        model_update(i, xi, ei, li, oi, (i == 1) ? 32'(p6i) : 32'(p4i), ez[i]);
  endtask

  task automatic run_bits(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b0, bits[k], 1'b1, 1'b0, 1'b0, 4'hA, 6'h0A);
  endtask

  initial begin
    rst = 1'b1; x = 1'b0; en = 1'b0; load = 1'b0; overlap = 1'b0;
    pat4 = 4'hA; pat6 = 6'h0A;

    // Reset defaults
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 6'h0A);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 6'h0A);
    check("rst_armed", 32'(aa), 32'd0);
    check("rst_cnt", 32'(cnt_d4), 32'd0);

    // Default non-overlap 1010 on 1010100
    hits4 = 0;
    run_bits(32'b1010100, 7);
    check("nonovl_hits", 32'(hits4), 32'd1);
    check("nonovl_cnt", 32'(cnt_d4), CNT_ON ? 32'd1 : 32'd0);

    // Overlap 1010 on 101010
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 6'h0A);
    check("load_cnt_clr", 32'(cnt_d4), 32'd0);
    hits4 = 0;
    run_bits(32'b101010, 6);
    check("ovl_hits", 32'(hits4), 32'd2);
    check("ovl_cnt", 32'(cnt_d4), CNT_ON ? 32'd2 : 32'd0);

    // en gaps inside a match
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 6'h0A);
    hits4 = 0;
    run_bits(32'b101, 3);
    for (int k = 0; k < 3; k++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 4'hA, 6'h0A);
    check("gap_hits", 32'(hits4), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 6'h0A);
    check("gap_final_hits", 32'(hits4), 32'd1);

    // PAT_W = 6 pattern 110011
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 6'b110011);
    hits6 = 0;
    for (int k = 5; k >= 0; k--) begin
      logic [5:0] s;
      s = 6'b110011;
      step(1'b0, s[k], 1'b1, 1'b0, 1'b0, 4'hA, 6'b110011);
    end
    check("w6_hits", 32'(hits6), 32'd1);

    // Counter saturation, CNT_W = 2
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 6'h3F);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 6'h3F);
    check("sat_cnt", 32'(cnt_c2), CNT_ON ? 32'd3 : 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, 6'h0A);
    check("sat_clr", 32'(cnt_c2), 32'd0);

    // Reset mid-sequence
    hits4 = 0;
    run_bits(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 6'h0A);
    check("midrst_armed", 32'(aa[0]), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 6'h0A);
    check("midrst_hits", 32'(hits4), 32'd0);
    check("midrst_armed2", 32'(aa[0]), 32'd0);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      bit r, li, ei;
      r  = ($urandom_range(0, 99) == 0);
      li = ($urandom_range(0, 29) == 0);
      ei = ($urandom_range(0, 3) != 0);
      step(r, 1'($urandom), ei, li, 1'($urandom),
           4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_det_param
`default_nettype wire
